mem_port_arbiter: RTL

- Shares the single-ported, byte-addressed, big-endian unified memory between the pipeline's instruction-fetch requester and data (load/store) requester.
- Sits between the IF/MEM stages and the memory array.
- Serialises accesses with a req/ready handshake and holds each access for a fixed number of cycles.
- Uses data-first priority with a starvation guard so fetch always makes progress.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// load/store traffic. Data has priority, but fetch is forced through after MAX_WAIT consecutive data grants.
module mem_port_arbiter #(
  parameter int LAT      = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_half,
  input  logic        d_byte,
  input  logic        d_ext,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] m_addr,
  output logic        m_we,
  output logic [31:0] m_wdata,
  output logic        m_half,
  output logic        m_byte,
  output logic        m_ext,
  input  logic [31:0] m_rdata,
  output logic        fetch_stall,
  output logic        data_stall
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            half_q, half_d;
  logic            byte_q, byte_d;
  logic            ext_q, ext_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;

  logic grant_data;
  logic grant_fetch;

  // Data wins a tie unless fetch has already waited out MAX_WAIT data grants.
  assign grant_data  = d_req && !(if_req && (wait_cnt_q == WW'(MAX_WAIT)));
  assign grant_fetch = if_req && !grant_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_data || grant_fetch) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    half_d     = half_q;
    byte_d     = byte_q;
    ext_d      = ext_q;
    cnt_d      = cnt_q;
    wait_cnt_d = wait_cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (state_q == IDLE) begin
      if (grant_data) begin
        owner_d = 1'b1;
        addr_d  = d_addr;
        wdata_d = d_wdata;
        we_d    = d_we;
        half_d  = d_half;
        byte_d  = d_byte;
        ext_d   = d_ext;
        cnt_d   = CW'(LAT - 1);
        if (if_req && (wait_cnt_q != WW'(MAX_WAIT))) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end else if (grant_fetch) begin
        owner_d    = 1'b0;
        addr_d     = if_addr;
        wdata_d    = '0;
        we_d       = 1'b0;
        half_d     = 1'b0;
        byte_d     = 1'b0;
        ext_d      = 1'b0;
        cnt_d      = CW'(LAT - 1);
        wait_cnt_d = '0;
      end
    end else if (state_q == BUSY) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (owner_q) begin
        d_rdata_d = m_rdata;
      end else begin
        if_rdata_d = m_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      half_q     <= 1'b0;
      byte_q     <= 1'b0;
      ext_q      <= 1'b0;
      cnt_q      <= '0;
      wait_cnt_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      half_q     <= half_d;
      byte_q     <= byte_d;
      ext_q      <= ext_d;
      cnt_q      <= cnt_d;
      wait_cnt_q <= wait_cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Write enable only on the last busy cycle so a store lands exactly once.
  always_comb begin
    m_addr   = '0;
    m_we     = 1'b0;
    m_wdata  = '0;
    m_half   = 1'b0;
    m_byte   = 1'b0;
    m_ext    = 1'b0;
    if_ready = 1'b0;
    d_ready  = 1'b0;
    case (state_q)
      BUSY: begin
        m_addr  = addr_q;
        m_we    = we_q && (cnt_q == '0);
        m_wdata = wdata_q;
        m_half  = half_q;
        m_byte  = byte_q;
        m_ext   = ext_q;
      end
      DONE: begin
        if_ready = !owner_q;
        d_ready  = owner_q;
      end
      default: ;
    endcase
    fetch_stall = if_req && !((state_q == DONE) && !owner_q);
    data_stall  = d_req && !((state_q == DONE) && owner_q);
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
